temperature_sample_scheduler: RTL and testbench
===============================================

// Module: temperature_sample_scheduler
// PURPOSE
//  Shares one combinational temperature range checker between NUM_CH patient sensor channels.
//  - Arbitrates channels round-robin and captures one 8-bit sample per grant.
//  - Tracks consecutive out-of-range samples per channel.
//  - Raises a per-channel sticky alarm, cleared by software ack; sits between sensor front-ends and the alarm/display logic.
// PARAMETERS
//  NUM_CH        4   number of sensor channels (2..16)
//  CONFIRM_COUNT 3   consecutive abnormal samples required to raise alarm (1..15)
// PORTS
//  clock           in   1         system clock, all logic on rising edge
//  nReset          in   1         synchronous, active-low reset
//  sampleValid     in   NUM_CH    channel i holds a sample; once high, held until its sampleReady
//  sampleData      in   NUM_CH*8  channel i temperature, unsigned degC, bits [8i+7:8i]
//  sampleReady     out  NUM_CH    one-hot grant; transfer when sampleValid[i]&sampleReady[i]
//  alarmAck        in   NUM_CH    clears alarm[i] (level, sampled each cycle)
//  resultValid     out  1         one-cycle pulse per evaluated sample
//  resultChannel   out  $clog2(NUM_CH)  channel of current result
//  resultAbnormal  out  1         evaluated sample was out of range
//  alarm           out  NUM_CH    sticky per-channel alarm
//  busy            out  1         FSM not in IDLE
// BEHAVIOUR
//  Reset (nReset=0 at edge): state=IDLE, rrPtr=0, sampleReady=0, resultValid=0, resultChannel=0,
//   resultAbnormal=0, alarm=0, all abnCount=0, capture reg=0, busy=0. Applies mid-transfer too; a sample in flight is dropped.
//  Abnormal := temp > TEMP_HIGH(39) || temp < TEMP_LOW(35); 35..39 inclusive is normal; 0 and 255 are abnormal.
//  FSM (all outputs registered):
//   IDLE  : if |sampleValid, grantIdx <= first valid channel at/after rrPtr (wrapping NUM_CH-1 -> 0); go GRANT.
//   GRANT : sampleReady = onehot(grantIdx).
//           If sampleValid[grantIdx]: capture sampleData slice; rrPtr <= grantIdx+1 mod NUM_CH; go EVAL.
//           Else (protocol violation): no capture, rrPtr unchanged; go IDLE.
//   EVAL  : run checker on capture; update abnCount[grantIdx].
//           resultValid=1, resultChannel=grantIdx and resultAbnormal visible the cycle after EVAL; go IDLE.
//  Timing:
//   - Valid seen in IDLE at cycle t -> ready high at t+1 -> resultValid at t+3.
//   - Max throughput 1 sample per 3 cycles.
//   - A continuously valid channel is served at least once every 3*NUM_CH cycles.
//  Counter:
//   - abnCount width $clog2(CONFIRM_COUNT+1), saturating at CONFIRM_COUNT.
//   - Abnormal sample: +1 (sat). Normal sample: 0.
//  Alarm:
//   - alarm[i] sets when an abnormal sample brings/keeps abnCount[i] at CONFIRM_COUNT.
//   - Clears when alarmAck[i]=1; set in same cycle as ack -> set wins.
//   - Ack does not touch abnCount; a further abnormal sample re-raises alarm immediately.
//  Channels other than grantIdx are never modified.
// STRUCTURE
//  Package temp_monitor_pkg: TEMP_LOW=8'd35, TEMP_HIGH=8'd39, state enum IDLE/GRANT/EVAL (2-bit localparams).
//  Sub-module temp_range_check (8-bit temp in, abnormal out, combinational, uses package bounds).
//  Round-robin pick as a function inside this block; no further hierarchy.
// TESTING
//  1. Reset mid-GRANT on ch2 -> next cycle all outputs 0, no resultValid, alarm=0.
//  2. Ch0 only, temps 36,35,39 -> three resultValid pulses, each 3 cycles after valid; resultAbnormal=0; alarm=0.
//  3. Ch1 temps 40,34,41 (CONFIRM_COUNT=3) -> alarm[1] rises after 3rd result; 40,34,38 -> no alarm (count reset).
//  4. All 4 channels valid continuously -> grant order 0,1,2,3,0; each ready pulse one cycle.
//  5. alarm[2] set; alarmAck[2]=1 same cycle as 4th abnormal ch2 sample -> alarm[2] stays 1; next ack with no sample -> 0.
//  6. Ch3 drops valid during GRANT -> no capture, no resultValid, rrPtr unchanged, ch3 re-granted next.

Source files
------------

// File: rtl/temp_monitor_pkg.sv
// Shared constants for the temperature monitor: the normal band bounds and the
// scheduler state encoding.
package temp_monitor_pkg;

   localparam logic [7:0] TEMP_LOW  = 8'd35;
   localparam logic [7:0] TEMP_HIGH = 8'd39;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      EVAL  = 2'd2
   } state_e;

endpackage

// File: rtl/temp_range_check.sv
// Combinational range checker: a reading is abnormal when it lies outside
// the inclusive band TEMP_LOW..TEMP_HIGH.
module temp_range_check
   import temp_monitor_pkg::*;
(
   input  logic [7:0] temp,
   output logic       abnormal
);

   assign abnormal = (temp > TEMP_HIGH) || (temp < TEMP_LOW);

endmodule

// File: rtl/temperature_sample_scheduler.sv
// Round-robin scheduler sharing one range checker between NUM_CH sensor
// channels, with per-channel abnormal-run counters and sticky alarms.
//
// Handshake: a channel raises sampleValid[i] and holds it (with its data)
// until sampleReady[i]; a sample moves on the rising edge where both are high.
module temperature_sample_scheduler
   import temp_monitor_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int CONFIRM_COUNT = 3
) (
   input  logic                        clock,
   input  logic                        nReset,
   input  logic [NUM_CH-1:0]           sampleValid,
   input  logic [NUM_CH*8-1:0]         sampleData,
   output logic [NUM_CH-1:0]           sampleReady,
   input  logic [NUM_CH-1:0]           alarmAck,
   output logic                        resultValid,
   output logic [$clog2(NUM_CH)-1:0]   resultChannel,
   output logic                        resultAbnormal,
   output logic [NUM_CH-1:0]           alarm,
   output logic                        busy
);

   localparam int IW = $clog2(NUM_CH);
   localparam int CW = $clog2(CONFIRM_COUNT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(CONFIRM_COUNT);
   localparam logic [IW-1:0] LAST_CH = IW'(NUM_CH - 1);

   state_e            state_q, state_d;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]     grant_idx_q, grant_idx_d;
   logic [IW-1:0]     res_ch_q, res_ch_d;
   logic [IW-1:0]     pick_idx;
   logic [NUM_CH-1:0] ready_q, ready_d;
   logic [NUM_CH-1:0] alarm_q, alarm_d;
   logic [7:0]        capture_q, capture_d;
   logic              res_valid_q, res_valid_d;
   logic              res_abn_q, res_abn_d;
   logic              cap_abnormal;
   logic [CW-1:0]     cnt_next;
   logic [CW-1:0]     abn_count_q [NUM_CH];
   logic [CW-1:0]     abn_count_d [NUM_CH];

   // First requesting channel at or after ptr, wrapping; lowest offset wins.
   function automatic logic [IW-1:0] rr_pick(input logic [NUM_CH-1:0] valid,
                                             input logic [IW-1:0]     ptr);
      logic [IW-1:0] pick;
      logic [IW-1:0] sel;
      int            idx;
      pick = ptr;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         sel = IW'(idx);
         if (valid[sel]) pick = sel;
      end
      return pick;
   endfunction

   temp_range_check u_check (
      .temp     (capture_q),
      .abnormal (cap_abnormal)
   );

   always_comb begin
      pick_idx    = rr_pick(sampleValid, rr_ptr_q);
      cnt_next    = (abn_count_q[grant_idx_q] == CNT_MAX) ? CNT_MAX
                                                          : abn_count_q[grant_idx_q] + CW'(1);
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_idx_d = grant_idx_q;
      res_ch_d    = res_ch_q;
      res_abn_d   = res_abn_q;
      capture_d   = capture_q;
      abn_count_d = abn_count_q;
      ready_d     = '0;
      res_valid_d = 1'b0;
      // A set in the same cycle as an ack overrides the ack below.
      alarm_d     = alarm_q & ~alarmAck;
      case (state_q)
         IDLE: begin
            if (|sampleValid) begin
               grant_idx_d = pick_idx;
               ready_d     = NUM_CH'(1) << pick_idx;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (sampleValid[grant_idx_q]) begin
               capture_d = sampleData[{grant_idx_q, 3'b000} +: 8];
               rr_ptr_d  = (grant_idx_q == LAST_CH) ? '0 : grant_idx_q + IW'(1);
               state_d   = EVAL;
            end else begin
               state_d = IDLE;
            end
         end
         EVAL: begin
            res_valid_d = 1'b1;
            res_ch_d    = grant_idx_q;
            res_abn_d   = cap_abnormal;
            if (cap_abnormal) begin
               abn_count_d[grant_idx_q] = cnt_next;
               if (cnt_next == CNT_MAX) alarm_d[grant_idx_q] = 1'b1;
            end else begin
               abn_count_d[grant_idx_q] = '0;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!nReset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_idx_q <= '0;
         res_ch_q    <= '0;
         res_abn_q   <= 1'b0;
         res_valid_q <= 1'b0;
         capture_q   <= '0;
         ready_q     <= '0;
         alarm_q     <= '0;
         for (int i = 0; i < NUM_CH; i++) abn_count_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_idx_q <= grant_idx_d;
         res_ch_q    <= res_ch_d;
         res_abn_q   <= res_abn_d;
         res_valid_q <= res_valid_d;
         capture_q   <= capture_d;
         ready_q     <= ready_d;
         alarm_q     <= alarm_d;
         abn_count_q <= abn_count_d;
      end
   end

   assign sampleReady    = ready_q;
   assign resultValid    = res_valid_q;
   assign resultChannel  = res_ch_q;
   assign resultAbnormal = res_abn_q;
   assign alarm          = alarm_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_temperature_sample_scheduler.sv
// Bench for temperature_sample_scheduler: directed scenarios plus a random
// run checked against a transaction-level reference model.
module tb_temperature_sample_scheduler;

   logic        clock = 1'b0;
   logic        nReset;
   logic [3:0]  sampleValid;
   logic [31:0] sampleData;
   logic [3:0]  sampleReady;
   logic [3:0]  alarmAck;
   logic        resultValid;
   logic [1:0]  resultChannel;
   logic        resultAbnormal;
   logic [3:0]  alarm;
   logic        busy;

   int errors = 0;
   int checks = 0;

   temperature_sample_scheduler #(.NUM_CH(4), .CONFIRM_COUNT(3)) dut (
      .clock          (clock),
      .nReset         (nReset),
      .sampleValid    (sampleValid),
      .sampleData     (sampleData),
      .sampleReady    (sampleReady),
      .alarmAck       (alarmAck),
      .resultValid    (resultValid),
      .resultChannel  (resultChannel),
      .resultAbnormal (resultAbnormal),
      .alarm          (alarm),
      .busy           (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic do_reset();
      nReset      = 1'b0;
      sampleValid = '0;
      sampleData  = '0;
      alarmAck    = '0;
      tick();
      tick();
      nReset = 1'b1;
   endtask

   // ---------------- reference helpers ----------------
   function automatic bit is_abn(input logic [7:0] t);
      return (t > 8'd39) || (t < 8'd35);
   endfunction

   function automatic int rr_ref(input logic [3:0] v, input int start);
      for (int k = 0; k < 4; k++)
         if (v[(start + k) % 4]) return (start + k) % 4;
      return start;
   endfunction

   function automatic logic [7:0] rand_temp();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 8'd0;
      if (r == 1) return 8'd255;
      return 8'($urandom_range(32, 42));
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_ch(input int c, input bit v, input logic [7:0] t);
      sampleValid[c]       = v;
      sampleData[c*8 +: 8] = t;
   endtask

   task automatic wait_ready(input int c, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (sampleReady[c]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Drives one sample on channel c; latencies counted in cycles from valid.
   task automatic send_sample(input int c, input logic [7:0] t, output int rlat,
                              output int res_lat, output logic r_abn,
                              output logic [1:0] r_ch, output logic [3:0] r_alarm);
      int cnt;
      set_ch(c, 1'b1, t);
      rlat    = -1;
      res_lat = -1;
      r_abn   = 1'bx;
      r_ch    = 2'bxx;
      r_alarm = 4'bxxxx;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (sampleReady[c]) begin
            rlat = i;
            break;
         end
      end
      if (rlat < 0) begin
         set_ch(c, 1'b0, 8'd0);
         return;
      end
      tick();
      set_ch(c, 1'b0, 8'd0);
      cnt = rlat + 1;
      for (int i = 0; i < 10; i++) begin
         if (resultValid) begin
            res_lat = cnt;
            r_abn   = resultAbnormal;
            r_ch    = resultChannel;
            r_alarm = alarm;
            break;
         end
         tick();
         cnt++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bit ok;
      do_reset();
      checks++; if (sampleReady !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0000", sampleReady); end
      checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b exp 0", resultValid); end
      checks++; if (resultChannel !== 2'd0) begin errors++; $display("FAIL reset_rch: got %0d exp 0", resultChannel); end
      checks++; if (resultAbnormal !== 1'b0) begin errors++; $display("FAIL reset_rabn: got %b exp 0", resultAbnormal); end
      checks++; if (alarm !== 4'b0) begin errors++; $display("FAIL reset_alarm: got %b exp 0000", alarm); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      // reset while ch2 is in its grant cycle
      set_ch(2, 1'b1, 8'd50);
      wait_ready(2, ok);
      checks++; if (!ok) begin errors++; $display("FAIL midgrant_ready: got timeout exp ready[2]"); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midgrant_busy: got %b exp 1", busy); end
      nReset = 1'b0;
      tick();
      checks++; if ({sampleReady, resultValid, resultChannel, resultAbnormal, alarm, busy} !== 13'b0)
         begin errors++; $display("FAIL midgrant_outputs: got %b exp all zero", {sampleReady, resultValid, resultChannel, resultAbnormal, alarm, busy}); end
      nReset = 1'b1;
      set_ch(2, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL midgrant_dropped: got %b exp 0 at cycle %0d", resultValid, i); end
      end
   endtask

   task automatic test_normal_ch0();
      logic [7:0] temps [3];
      int rl, resl;
      logic ra;
      logic [1:0] rc;
      logic [3:0] al;
      temps = '{8'd36, 8'd35, 8'd39};
      do_reset();
      foreach (temps[i]) begin
         send_sample(0, temps[i], rl, resl, ra, rc, al);
         checks++; if (rl !== 1) begin errors++; $display("FAIL normal_ready_lat: got %0d exp 1", rl); end
         checks++; if (resl !== 3) begin errors++; $display("FAIL normal_result_lat: got %0d exp 3", resl); end
         checks++; if (rc !== 2'd0) begin errors++; $display("FAIL normal_channel: got %0d exp 0", rc); end
         checks++; if (ra !== 1'b0) begin errors++; $display("FAIL normal_abnormal t=%0d: got %b exp 0", temps[i], ra); end
         checks++; if (al !== 4'b0) begin errors++; $display("FAIL normal_alarm: got %b exp 0000", al); end
      end
   endtask

   task automatic test_confirm();
      logic [7:0] seq_a [3];
      logic [7:0] seq_b [4];
      int rl, resl;
      logic ra;
      logic [1:0] rc;
      logic [3:0] al;
      seq_a = '{8'd40, 8'd34, 8'd41};
      seq_b = '{8'd37, 8'd40, 8'd34, 8'd38};
      do_reset();
      foreach (seq_a[i]) begin
         send_sample(1, seq_a[i], rl, resl, ra, rc, al);
         checks++; if (ra !== 1'b1) begin errors++; $display("FAIL confirm_abn t=%0d: got %b exp 1", seq_a[i], ra); end
         checks++; if (rc !== 2'd1) begin errors++; $display("FAIL confirm_channel: got %0d exp 1", rc); end
         checks++; if (al !== ((i == 2) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL confirm_alarm step %0d: got %b exp %b", i, al, (i == 2) ? 4'b0010 : 4'b0000); end
      end
      alarmAck = 4'b0010;
      tick();
      alarmAck = 4'b0000;
      checks++; if (alarm !== 4'b0) begin errors++; $display("FAIL confirm_ack_clear: got %b exp 0000", alarm); end
      foreach (seq_b[i]) begin
         send_sample(1, seq_b[i], rl, resl, ra, rc, al);
         checks++; if (ra !== is_abn(seq_b[i])) begin errors++; $display("FAIL confirm_reset_abn t=%0d: got %b exp %b", seq_b[i], ra, is_abn(seq_b[i])); end
         checks++; if (al !== 4'b0) begin errors++; $display("FAIL confirm_reset_alarm step %0d: got %b exp 0000", i, al); end
      end
   endtask

   task automatic test_back_to_back();
      int order [5];
      int got, last, cyc;
      order = '{0, 1, 2, 3, 0};
      got = 0;
      last = 0;
      cyc = 0;
      do_reset();
      for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 8'd37);
      while (got < 5 && cyc < 60) begin
         tick();
         cyc++;
         if (sampleReady !== 4'b0) begin
            checks++; if (sampleReady !== (4'b0001 << order[got])) begin errors++; $display("FAIL rr_order grant %0d: got %b exp %b", got, sampleReady, 4'b0001 << order[got]); end
            if (got > 0) begin
               checks++; if (cyc - last != 3) begin errors++; $display("FAIL rr_spacing: got %0d exp 3", cyc - last); end
            end
            last = cyc;
            got++;
            tick();
            cyc++;
            checks++; if (sampleReady !== 4'b0) begin errors++; $display("FAIL rr_pulse_width: got %b exp 0000", sampleReady); end
         end
      end
      checks++; if (got != 5) begin errors++; $display("FAIL rr_timeout: got %0d grants exp 5", got); end
      sampleValid = '0;
      repeat (6) tick();
   endtask

   task automatic test_ack_vs_set();
      int rl, resl;
      logic ra;
      logic [1:0] rc;
      logic [3:0] al;
      bit ok;
      do_reset();
      for (int i = 0; i < 3; i++) send_sample(2, 8'd50, rl, resl, ra, rc, al);
      checks++; if (al !== 4'b0100) begin errors++; $display("FAIL ack_alarm_set: got %b exp 0100", al); end
      set_ch(2, 1'b1, 8'd50);
      wait_ready(2, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ack_ready: got timeout exp ready[2]"); end
      tick();
      set_ch(2, 1'b0, 8'd0);
      alarmAck = 4'b0100;
      tick();
      checks++; if (resultValid !== 1'b1) begin errors++; $display("FAIL ack_result: got %b exp 1", resultValid); end
      checks++; if (alarm !== 4'b0100) begin errors++; $display("FAIL ack_set_wins: got %b exp 0100", alarm); end
      tick();
      alarmAck = 4'b0000;
      checks++; if (alarm !== 4'b0000) begin errors++; $display("FAIL ack_clear: got %b exp 0000", alarm); end
      send_sample(2, 8'd255, rl, resl, ra, rc, al);
      checks++; if (al !== 4'b0100) begin errors++; $display("FAIL ack_reraise: got %b exp 0100", al); end
   endtask

   task automatic test_drop_valid();
      int rl, resl;
      logic ra;
      logic [1:0] rc;
      logic [3:0] al;
      bit ok;
      do_reset();
      send_sample(2, 8'd37, rl, resl, ra, rc, al);
      set_ch(3, 1'b1, 8'd37);
      wait_ready(3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL drop_ready: got timeout exp ready[3]"); end
      set_ch(3, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL drop_no_result: got %b exp 0", resultValid); end
      end
      set_ch(0, 1'b1, 8'd37);
      set_ch(3, 1'b1, 8'd44);
      tick();
      checks++; if (sampleReady !== 4'b1000) begin errors++; $display("FAIL drop_regrant: got %b exp 1000", sampleReady); end
      tick();
      set_ch(3, 1'b0, 8'd0);
      tick();
      checks++; if ({resultValid, resultChannel, resultAbnormal} !== 4'b1111) begin errors++; $display("FAIL drop_regrant_result: got %b exp 1111", {resultValid, resultChannel, resultAbnormal}); end
      wait_ready(0, ok);
      tick();
      set_ch(0, 1'b0, 8'd0);
      repeat (4) tick();
   endtask

   task automatic test_random();
      int idle_edge, c, ch, rr;
      int cnt [4];
      logic [3:0] exp_next, drop_mask, new_drop, ack_now, set_bits, al;
      logic [9:0] exp_q [$];
      int exp_cyc_q [$];
      logic [9:0] e;
      do_reset();
      rr = 0;
      idle_edge = 0;
      drop_mask = '0;
      al = '0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int n = 0; n < 900; n++) begin
         new_drop = sampleReady & sampleValid;
         for (int i = 0; i < 4; i++) begin
            if (drop_mask[i]) begin
               if ($urandom_range(0, 1) == 1) set_ch(i, 1'b1, rand_temp());
               else set_ch(i, 1'b0, 8'd0);
            end else if (!sampleValid[i] && $urandom_range(0, 3) == 0) begin
               set_ch(i, 1'b1, rand_temp());
            end
            alarmAck[i] = ($urandom_range(0, 9) == 0);
         end
         drop_mask = new_drop;
         if (n + 1 >= idle_edge && sampleValid != 4'b0) begin
            c = rr_ref(sampleValid, rr);
            exp_next = 4'b0001 << c;
            exp_cyc_q.push_back(n + 3);
            exp_q.push_back({2'(c), sampleData[c*8 +: 8]});
            rr = (c + 1) % 4;
            idle_edge = n + 4;
         end else begin
            exp_next = 4'b0;
         end
         ack_now = alarmAck;
         tick();
         checks++; if (sampleReady !== exp_next) begin errors++; $display("FAIL rand_ready cycle %0d: got %b exp %b", n + 1, sampleReady, exp_next); end
         set_bits = '0;
         if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == n + 1) begin
            void'(exp_cyc_q.pop_front());
            e = exp_q.pop_front();
            ch = int'(e[9:8]);
            checks++; if ({resultValid, resultChannel, resultAbnormal} !== {1'b1, e[9:8], is_abn(e[7:0])})
               begin errors++; $display("FAIL rand_result cycle %0d: got v=%b ch=%0d abn=%b exp v=1 ch=%0d abn=%b", n + 1, resultValid, resultChannel, resultAbnormal, e[9:8], is_abn(e[7:0])); end
            if (is_abn(e[7:0])) begin
               cnt[ch] = (cnt[ch] >= 3) ? 3 : cnt[ch] + 1;
               if (cnt[ch] == 3) set_bits[ch] = 1'b1;
            end else begin
               cnt[ch] = 0;
            end
         end else begin
            checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL rand_spurious_result cycle %0d: got %b exp 0", n + 1, resultValid); end
         end
         al = (al & ~ack_now) | set_bits;
         checks++; if (alarm !== al) begin errors++; $display("FAIL rand_alarm cycle %0d: got %b exp %b", n + 1, alarm, al); end
      end
      sampleValid = '0;
      alarmAck = '0;
      repeat (4) tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      nReset      = 1'b0;
      sampleValid = '0;
      sampleData  = '0;
      alarmAck    = '0;
      test_reset();
      test_normal_ch0();
      test_confirm();
      test_back_to_back();
      test_ack_vs_set();
      test_drop_valid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
